cmos_gray_gen: RTL and testbench

CMOS_GRAY_GEN -- requirements
Module: cmos_gray_gen

---
 rtl/cmos_gray_gen.sv | 154 +++++++++++++++
 tb/tb_cmos_gray_gen.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmos_gray_gen.sv
// cmos_gray_gen: converts a DVP RGB565 byte stream into 8-bit luma, one strobe per pixel,
// and reports frame/line framing pulses, line-position flags and the measured line width.
module cmos_gray_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmos_vsync,
    input  logic        cmos_href,
    input  logic [7:0]  cmos_data,
    input  logic [15:0] cmos_v,
    output logic        pic_start,
    output logic        href_start,
    output logic        href_end,
    output logic        first_href,
    output logic        second_href,
    output logic        last_href,
    output logic        gray_en,
    output logic [7:0]  gray_data,
    output logic [15:0] cmos_h
);

    typedef enum logic [1:0] {IDLE, WAIT_LINE, LINE} state_e;

    state_e      state_q, state_d;
    logic        vsync_q, vsync_prev_q, href_q, href_prev_q;
    logic [7:0]  data_q, hi_q;
    logic        phase_q, cur_phase, byte_vld, href_fall;
    logic [7:0]  r8, g8, b8;
    logic [15:0] sum_d, sum_q;
    logic        sum_vld_q, gray_en_q, end_d1_q, end_d2_q;
    logic [7:0]  gray_data_q;
    logic [10:0] line_cnt_q;
    logic [15:0] pix_cnt_q, cmos_h_q;
    logic        first_q, second_q, last_q;
    logic        first_d, second_d, last_d;

    assign pic_start  = vsync_q & ~vsync_prev_q;
    assign href_start = href_q & ~href_prev_q & (state_q != IDLE) & ~pic_start;
    assign href_fall  = ~href_q & href_prev_q & (state_q == LINE) & ~pic_start;
    assign byte_vld   = href_q & ((state_q == LINE) | href_start) & ~pic_start;
    assign cur_phase  = href_start ? 1'b0 : phase_q;

    // Bit-replicated expansion of the 5/6/5 fields; the low byte is data_q, the high byte hi_q.
    assign r8    = {hi_q[7:3], hi_q[7:5]};
    assign g8    = {hi_q[2:0], data_q[7:5], hi_q[2:1]};
    assign b8    = {data_q[4:0], data_q[4:2]};
    assign sum_d = 16'd77 * {8'd0, r8} + 16'd150 * {8'd0, g8} + 16'd29 * {8'd0, b8};

    assign first_d  = (line_cnt_q == 11'd0);
    assign second_d = (line_cnt_q == 11'd1);
    assign last_d   = (cmos_v != 16'd0) && ({5'd0, line_cnt_q} == cmos_v - 16'd1);

    // Flags show the freshly evaluated line position in the href_start cycle itself.
    assign first_href  = ~pic_start & (href_start ? first_d  : first_q);
    assign second_href = ~pic_start & (href_start ? second_d : second_q);
    assign last_href   = ~pic_start & (href_start ? last_d   : last_q);

    assign href_end  = end_d2_q;
    assign gray_en   = gray_en_q;
    assign gray_data = gray_data_q;
    assign cmos_h    = cmos_h_q;

    always_comb begin
        // NOTE: default assigned first, so no branch leaves state_d unassigned and no latch is inferred.
        state_d = state_q;
        if (pic_start) begin
            state_d = WAIT_LINE;
        end else begin
            case (state_q)
                IDLE:      state_d = IDLE;
                WAIT_LINE: if (href_start) state_d = LINE;
                LINE:      if (href_end) state_d = WAIT_LINE;
                default:   state_d = IDLE;
            endcase
        end
    end

    // NOTE: every register uses <= so each update sees only pre-edge values, whatever the statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            vsync_q      <= 1'b0;
            vsync_prev_q <= 1'b0;
            href_q       <= 1'b0;
            href_prev_q  <= 1'b0;
            data_q       <= 8'd0;
            hi_q         <= 8'd0;
            phase_q      <= 1'b0;
            sum_q        <= 16'd0;
            sum_vld_q    <= 1'b0;
            gray_en_q    <= 1'b0;
            gray_data_q  <= 8'd0;
            end_d1_q     <= 1'b0;
            end_d2_q     <= 1'b0;
            line_cnt_q   <= 11'd0;
            pix_cnt_q    <= 16'd0;
            cmos_h_q     <= 16'd0;
            first_q      <= 1'b0;
            second_q     <= 1'b0;
            last_q       <= 1'b0;
        end else begin
            vsync_q      <= cmos_vsync;
            vsync_prev_q <= vsync_q;
            href_q       <= cmos_href;
            href_prev_q  <= href_q;
            data_q       <= cmos_data;
            state_q      <= state_d;

            if (pic_start) begin
                phase_q <= 1'b0;
            end else if (byte_vld) begin
                phase_q <= ~cur_phase;
                if (!cur_phase) hi_q <= data_q;
            end

            sum_vld_q <= byte_vld & cur_phase;
            if (byte_vld && cur_phase) sum_q <= sum_d;

            // A vsync edge flushes whatever pixel is still in flight.
            gray_en_q <= sum_vld_q & ~pic_start;
            if (sum_vld_q && !pic_start) gray_data_q <= sum_q[15:8];

            // href_end trails the fall by two cycles so it follows the line's last gray_en.
            end_d1_q <= href_fall;
            end_d2_q <= end_d1_q & ~pic_start;

            if (pic_start) begin
                line_cnt_q <= 11'd0;
            end else if (href_end && state_q == LINE && line_cnt_q != 11'h7FF) begin
                line_cnt_q <= line_cnt_q + 11'd1;
            end

            if (pic_start || href_start) begin
                pix_cnt_q <= 16'd0;
            end else if (gray_en_q) begin
                pix_cnt_q <= pix_cnt_q + 16'd1;
            end

            if (href_end && state_q == LINE && line_cnt_q == 11'd0 && !pic_start) begin
                cmos_h_q <= pix_cnt_q;
            end

            if (pic_start) begin
                first_q  <= 1'b0;
                second_q <= 1'b0;
                last_q   <= 1'b0;
            end else if (href_start) begin
                first_q  <= first_d;
                second_q <= second_d;
                last_q   <= last_d;
            end
        end
    end

endmodule

// File: tb/tb_cmos_gray_gen.sv
// tb_cmos_gray_gen: directed frame/line scenarios with random pixel bytes, checked against a
// pixel-level luma model and a line-index model of the framing flags.
module tb_cmos_gray_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmos_vsync, cmos_href;
    logic [7:0]  cmos_data;
    logic [15:0] cmos_v;
    logic        pic_start, href_start, href_end;
    logic        first_href, second_href, last_href;
    logic        gray_en;
    logic [7:0]  gray_data;
    logic [15:0] cmos_h;

    cmos_gray_gen dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmos_vsync  (cmos_vsync),
        .cmos_href   (cmos_href),
        .cmos_data   (cmos_data),
        .cmos_v      (cmos_v),
        .pic_start   (pic_start),
        .href_start  (href_start),
        .href_end    (href_end),
        .first_href  (first_href),
        .second_href (second_href),
        .last_href   (last_href),
        .gray_en     (gray_en),
        .gray_data   (gray_data),
        .cmos_h      (cmos_h)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation log, sampled on the falling edge away from the active edge.
    logic [7:0] gray_obs[$];
    int         gray_cyc[$];
    logic [2:0] flag_obs[$];
    int         n_he  = 0;
    int         n_pic = 0;
    int         he_cyc = 0;

    always @(negedge clk) begin
        if (gray_en) begin
            gray_obs.push_back(gray_data);
            gray_cyc.push_back(cyc);
        end
        if (href_start) flag_obs.push_back({first_href, second_href, last_href});
        if (href_end) begin
            n_he   <= n_he + 1;
            he_cyc <= cyc;
        end
        if (pic_start) n_pic <= n_pic + 1;
    end

    int         passed = 0;
    int         checks = 0;
    logic [7:0] bytes_q[$];
    int         model_line = 0;
    int         low1_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Luma from the RGB565 rules, using plain integer arithmetic.
    function automatic logic [7:0] luma(input logic [7:0] hi, input logic [7:0] lo);
        int r5, g6, b5, r8, g8, b8;
        r5 = int'(hi) / 8;
        g6 = (int'(hi) % 8) * 8 + int'(lo) / 32;
        b5 = int'(lo) % 32;
        r8 = r5 * 8 + r5 / 4;
        g8 = g6 * 4 + g6 / 16;
        b8 = b5 * 8 + b5 / 4;
        return 8'((77 * r8 + 150 * g8 + 29 * b8) / 256);
    endfunction

    task automatic fill_random(input int n);
        bytes_q.delete();
        for (int i = 0; i < n; i++) bytes_q.push_back(8'($urandom));
    endtask

    task automatic drive_line();
        for (int i = 0; i < bytes_q.size(); i++) begin
            @(negedge clk);
            cmos_href = 1'b1;
            cmos_data = bytes_q[i];
            if (i == 1) low1_cyc = cyc;
        end
        @(negedge clk);
        cmos_href = 1'b0;
        cmos_data = 8'd0;
        repeat (6) @(negedge clk);
    endtask

    task automatic frame_start(input logic [15:0] v);
        int pb;
        pb = n_pic;
        cmos_v = v;
        @(negedge clk);
        cmos_vsync = 1'b1;
        repeat (2) @(negedge clk);
        cmos_vsync = 1'b0;
        repeat (3) @(negedge clk);
        check("pic_start_count", n_pic - pb, 1);
        model_line = 0;
    endtask

    // Drive bytes_q as one full line and compare against the model.
    task automatic run_line();
        int         gb, hb, fb;
        logic [7:0] exp_q[$];
        logic [2:0] exp_f;
        gb = gray_obs.size();
        hb = n_he;
        fb = flag_obs.size();
        for (int i = 0; i + 1 < bytes_q.size(); i += 2) exp_q.push_back(luma(bytes_q[i], bytes_q[i+1]));
        exp_f = {model_line == 0, model_line == 1,
                 (cmos_v != 16'd0) && (model_line == int'(cmos_v) - 1)};
        drive_line();
        check("gray_count", gray_obs.size() - gb, exp_q.size());
        for (int i = 0; i < exp_q.size() && gb + i < gray_obs.size(); i++)
            check("gray_data", gray_obs[gb+i], exp_q[i]);
        if (exp_q.size() > 0 && gray_obs.size() > gb) begin
            check("gray_latency", gray_cyc[gb], low1_cyc + 3);
            check("href_end_after_gray", he_cyc > gray_cyc[gray_cyc.size()-1], 1);
        end
        check("href_end_count", n_he - hb, 1);
        check("href_start_count", flag_obs.size() - fb, 1);
        if (flag_obs.size() > fb) check("flags_at_start", flag_obs[fb], exp_f);
        check("flags_held", {first_href, second_href, last_href}, exp_f);
        model_line++;
    endtask

    task automatic check_idle_line(input string tag);
        int gb, fb, hb;
        gb = gray_obs.size();
        fb = flag_obs.size();
        hb = n_he;
        fill_random(6);
        drive_line();
        check({tag, "_gray"}, gray_obs.size() - gb, 0);
        check({tag, "_href_start"}, flag_obs.size() - fb, 0);
        check({tag, "_href_end"}, n_he - hb, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pic_start"}, pic_start, 0);
        check({tag, "_href_start"}, href_start, 0);
        check({tag, "_href_end"}, href_end, 0);
        check({tag, "_flags"}, {first_href, second_href, last_href}, 0);
        check({tag, "_gray_en"}, gray_en, 0);
        check({tag, "_gray_data"}, gray_data, 0);
        check({tag, "_cmos_h"}, cmos_h, 0);
    endtask

    initial begin
        int gb, hb, pb, fb;

        rst_n      = 1'b0;
        cmos_vsync = 1'b0;
        cmos_href  = 1'b0;
        cmos_data  = 8'd0;
        cmos_v     = 16'd4;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Lines before any vsync produce nothing.
        check_idle_line("pre_vsync");

        // Known pixels, then a random line.
        frame_start(16'd4);
        bytes_q = '{8'hFF, 8'hFF};
        run_line();
        check("white_model", luma(8'hFF, 8'hFF), 8'hFF);
        bytes_q = '{8'hF8, 8'h00};
        run_line();
        fill_random(20);
        run_line();

        // Full frame: 4 lines of 640 pixels.
        frame_start(16'd4);
        for (int ln = 0; ln < 4; ln++) begin
            fill_random(1280);
            run_line();
            check("cmos_h", cmos_h, 640);
        end

        // Odd byte count drops the trailing byte; cmos_v = 0 never flags a last line.
        frame_start(16'd0);
        fill_random(5);
        run_line();
        check("cmos_h_odd", cmos_h, 2);
        fill_random(8);
        run_line();
        check("cmos_h_line1_unchanged", cmos_h, 2);

        // vsync in the middle of a line aborts it.
        frame_start(16'd4);
        fill_random(12);
        gb = gray_obs.size();
        hb = n_he;
        pb = n_pic;
        fb = flag_obs.size();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            cmos_href = 1'b1;
            cmos_data = bytes_q[i];
            if (i == 8) cmos_vsync = 1'b1;
        end
        @(negedge clk);
        cmos_href = 1'b0;
        repeat (6) @(negedge clk);
        cmos_vsync = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_gray_count", gray_obs.size() - gb, 3);
        for (int i = 0; i < 3 && gb + i < gray_obs.size(); i++)
            check("abort_gray_data", gray_obs[gb+i], luma(bytes_q[2*i], bytes_q[2*i+1]));
        check("abort_href_end", n_he - hb, 0);
        check("abort_pic_start", n_pic - pb, 1);
        check("abort_href_start", flag_obs.size() - fb, 1);
        check("abort_cmos_h", cmos_h, 2);
        model_line = 0;
        fill_random(6);
        run_line();
        check("after_abort_cmos_h", cmos_h, 3);

        // Reset in the middle of a line drops the in-flight pixel.
        frame_start(16'd4);
        fill_random(10);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cmos_href = 1'b1;
            cmos_data = bytes_q[i];
        end
        @(negedge clk);
        cmos_data = bytes_q[6];
        rst_n = 1'b0;
        @(negedge clk);
        gb = gray_obs.size();
        check_reset_outputs("midline_reset");
        cmos_href = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("midline_reset_no_gray", gray_obs.size() - gb, 0);
        check_idle_line("post_reset");
        check("post_reset_cmos_h", cmos_h, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
